// File: rtl/mem_stream_master.sv
// Block-transfer bus initiator for the unified memory: streams memory words out
// (read mode) or commits a valid/ready input stream into memory (write mode).
module mem_stream_master #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_cnt,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [31:0]      Address,
  output logic [31:0]      Write_data,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [31:0]      Mem_data,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_HOLD  = 3'd2,
    WR_WAIT  = 3'd3,
    WR_ISSUE = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic             rvalid_reg, rvalid_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      rdata_reg     <= 32'h0;
      rvalid_reg    <= 1'b0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      rvalid_reg    <= rvalid_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    rvalid_next    = rvalid_reg;
    remaining_next = remaining_reg;

    case (state_reg)
      IDLE: begin
        // start beats abort here; abort is simply not looked at in IDLE
        if (start) begin
          addr_next      = {base_addr[31:2], 2'b00};
          remaining_next = word_cnt;
          if (word_cnt == '0)
            state_next = DONE;
          else if (dir)
            state_next = WR_WAIT;
          else
            state_next = RD_ISSUE;
        end
      end

      RD_ISSUE: begin
        // The read itself completes even when aborted; only the valid is withheld.
        rdata_next     = Mem_data;
        addr_next      = addr_reg + 32'd4;
        remaining_next = remaining_reg - CNT_W'(1);
        if (abort) begin
          rvalid_next = 1'b0;
          state_next  = DONE;
        end else begin
          rvalid_next = 1'b1;
          state_next  = RD_HOLD;
        end
      end

      RD_HOLD: begin
        if (abort) begin
          rvalid_next = 1'b0;
          state_next  = DONE;
        end else if (rd_ready) begin
          rvalid_next = 1'b0;
          state_next  = (remaining_reg == '0) ? DONE : RD_ISSUE;
        end
      end

      WR_WAIT: begin
        if (abort)
          state_next = DONE;
        else if (wr_valid) begin
          wdata_next = wr_data;
          state_next = WR_ISSUE;
        end
      end

      WR_ISSUE: begin
        addr_next      = addr_reg + 32'd4;
        remaining_next = remaining_reg - CNT_W'(1);
        if (abort || remaining_reg == CNT_W'(1))
          state_next = DONE;
        else
          state_next = WR_WAIT;
      end

      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode straight from the state so an async reset clears them at once.
  assign MemRead    = (state_reg == RD_ISSUE);
  assign MemWrite   = (state_reg == WR_ISSUE);
  assign wr_ready   = (state_reg == WR_WAIT);
  assign done       = (state_reg == DONE);
  assign busy       = (state_reg != IDLE) && (state_reg != DONE);
  assign Address    = addr_reg;
  assign Write_data = wdata_reg;
  assign rd_data    = rdata_reg;
  assign rd_valid   = rvalid_reg;

endmodule

// File: tb/tb_mem_stream_master.sv
// Scoreboard bench for mem_stream_master: a word memory model answers the bus,
// and expected addresses/data are queued when each command is issued.
module tb_mem_stream_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, dir, abort;
  logic [31:0] base_addr;
  logic [9:0]  word_cnt;
  logic        busy, done;
  logic [31:0] Address, Write_data, Mem_data, rd_data, wr_data;
  logic        MemRead, MemWrite, rd_valid, rd_ready, wr_valid, wr_ready;

  logic [31:0] mem [0:1023];

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];

  int checks = 0;
  int errors = 0;
  int mr_cycles = 0, mw_cycles = 0, done_pulses = 0, delivered = 0;
  logic [31:0] mon_v;

  mem_stream_master #(.CNT_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .base_addr(base_addr),
    .word_cnt(word_cnt), .abort(abort), .busy(busy), .done(done),
    .Address(Address), .Write_data(Write_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem_data(Mem_data), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  assign Mem_data = MemRead ? mem[Address[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (MemWrite) mem[Address[11:2]] = Write_data;
  end

  // Bus/stream monitor: pops the scoreboard as the DUT produces traffic.
  always @(negedge clk) begin
    checks++;
    if (MemRead && MemWrite) begin
      errors++;
      $display("FAIL strobe_excl: MemRead=%b MemWrite=%b, required not both high", MemRead, MemWrite);
    end
    if (MemRead) begin
      mr_cycles++;
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL rd_addr: unexpected read at %h, required none", Address);
      end else begin
        mon_v = exp_addr_q.pop_front();
        if (Address !== mon_v) begin
          errors++;
          $display("FAIL rd_addr: got %h, required %h", Address, mon_v);
        end else $display("read  addr %h", Address);
      end
    end
    if (MemWrite) begin
      mw_cycles++;
      checks++;
      if (exp_wa_q.size() == 0 || exp_wd_q.size() == 0) begin
        errors++;
        $display("FAIL wr_access: unexpected write %h at %h, required none", Write_data, Address);
      end else begin
        mon_v = exp_wa_q.pop_front();
        if (Address !== mon_v) begin
          errors++;
          $display("FAIL wr_addr: got %h, required %h", Address, mon_v);
        end
        mon_v = exp_wd_q.pop_front();
        if (Write_data !== mon_v) begin
          errors++;
          $display("FAIL wr_data: got %h, required %h", Write_data, mon_v);
        end else $display("write addr %h data %h", Address, Write_data);
      end
    end
    if (rd_valid && rd_ready) begin
      delivered++;
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_stream: unexpected word %h, required none", rd_data);
      end else begin
        mon_v = exp_rd_q.pop_front();
        if (rd_data !== mon_v) begin
          errors++;
          $display("FAIL rd_stream: got %h, required %h", rd_data, mon_v);
        end else $display("stream word %h", rd_data);
      end
    end
    if (done) done_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges after the current point until done is visible.
  task automatic wait_done(input string name, output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 60) begin
      tick();
      edges++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done=%b after %0d cycles, required 1", name, done, edges);
    end
  endtask

  task automatic push_word(input string name, input logic [31:0] d);
    bit hs = 1'b0;
    int n = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    while (!hs && n < 20) begin
      hs = wr_ready;
      tick();
      n++;
    end
    wr_valid = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL %s: wr_ready never seen, required handshake", name);
    end
  endtask

  task automatic issue(input logic d, input logic [31:0] b, input logic [9:0] c);
    dir = d; base_addr = b; word_cnt = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 0; dir = 0; abort = 0; base_addr = 0; word_cnt = 0;
    rd_ready = 0; wr_valid = 0; wr_data = 0;
    tick(); tick();
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (MemRead !== 1'b0)    begin errors++; $display("FAIL rst_memread: got %b, required 0", MemRead); end
    checks++; if (MemWrite !== 1'b0)   begin errors++; $display("FAIL rst_memwrite: got %b, required 0", MemWrite); end
    checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL rst_rd_valid: got %b, required 0", rd_valid); end
    checks++; if (wr_ready !== 1'b0)   begin errors++; $display("FAIL rst_wr_ready: got %b, required 0", wr_ready); end
    checks++; if (Address !== 32'h0)   begin errors++; $display("FAIL rst_addr: got %h, required 0", Address); end
    checks++; if (Write_data !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h, required 0", Write_data); end
    checks++; if (rd_data !== 32'h0)   begin errors++; $display("FAIL rst_rd_data: got %h, required 0", rd_data); end
    @(negedge clk) reset = 1'b1;
    tick();
    $display("reset checked");
  endtask

  task automatic test_read();
    int e, d0, dl0;
    mem[64] = 32'd20; mem[65] = 32'd20; mem[66] = 32'd2;
    exp_addr_q.push_back(32'h100); exp_addr_q.push_back(32'h104); exp_addr_q.push_back(32'h108);
    exp_rd_q.push_back(32'd20); exp_rd_q.push_back(32'd20); exp_rd_q.push_back(32'd2);
    d0 = done_pulses; dl0 = delivered;
    rd_ready = 1'b1;
    issue(1'b0, 32'h100, 10'd3);
    wait_done("t1_done", e);
    // ISSUE/HOLD pairs for 3 words, then DONE: done appears 6 edges after the start edge.
    checks++; if (e != 6) begin errors++; $display("FAIL t1_latency: got %0d, required 6", e); end
    tick(); tick();
    checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL t1_done_pulses: got %0d, required 1", done_pulses - d0); end
    checks++; if (delivered - dl0 != 3) begin errors++; $display("FAIL t1_words: got %0d, required 3", delivered - dl0); end
    checks++; if (exp_addr_q.size() + exp_rd_q.size() != 0) begin errors++; $display("FAIL t1_leftover: got %0d, required 0", exp_addr_q.size() + exp_rd_q.size()); end
  endtask

  task automatic test_backpressure();
    int e, n, dl0;
    exp_addr_q.push_back(32'h100); exp_addr_q.push_back(32'h104); exp_addr_q.push_back(32'h108);
    exp_rd_q.push_back(32'd20); exp_rd_q.push_back(32'd20); exp_rd_q.push_back(32'd2);
    dl0 = delivered;
    rd_ready = 1'b1;
    issue(1'b0, 32'h100, 10'd3);
    n = 0;
    while (!(rd_valid === 1'b1 && Address === 32'h108) && n < 20) begin tick(); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL t2_reach: second word not held, required RD_HOLD at 0x108"); end
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rd_valid !== 1'b1)     begin errors++; $display("FAIL t2_valid: got %b, required 1", rd_valid); end
      checks++; if (rd_data !== 32'd20)    begin errors++; $display("FAIL t2_data: got %h, required 14", rd_data); end
      checks++; if (MemRead !== 1'b0)      begin errors++; $display("FAIL t2_memread: got %b, required 0", MemRead); end
      checks++; if (Address !== 32'h108)   begin errors++; $display("FAIL t2_addr: got %h, required 108", Address); end
    end
    rd_ready = 1'b1;
    wait_done("t2_done", e);
    tick();
    checks++; if (delivered - dl0 != 3) begin errors++; $display("FAIL t2_words: got %0d, required 3", delivered - dl0); end
    checks++; if (exp_rd_q.size() != 0) begin errors++; $display("FAIL t2_leftover: got %0d, required 0", exp_rd_q.size()); end
  endtask

  task automatic test_write();
    int e, mw0;
    mw0 = mw_cycles;
    exp_wa_q.push_back(32'h400); exp_wd_q.push_back(32'hDEADBEEF);
    exp_wa_q.push_back(32'h404); exp_wd_q.push_back(32'h12345678);
    issue(1'b1, 32'h403, 10'd2);
    push_word("t3_hs0", 32'hDEADBEEF);
    tick(); tick(); tick();
    push_word("t3_hs1", 32'h12345678);
    wait_done("t3_done", e);
    checks++; if (Address !== 32'h408) begin errors++; $display("FAIL t3_addr: got %h, required 408", Address); end
    tick();
    checks++; if (mem[256] !== 32'hDEADBEEF) begin errors++; $display("FAIL t3_mem256: got %h, required deadbeef", mem[256]); end
    checks++; if (mem[257] !== 32'h12345678) begin errors++; $display("FAIL t3_mem257: got %h, required 12345678", mem[257]); end
    checks++; if (mw_cycles - mw0 != 2) begin errors++; $display("FAIL t3_memwrite_cycles: got %0d, required 2", mw_cycles - mw0); end
  endtask

  task automatic test_zero_and_busy_start();
    int e, d0, mr0, mw0;
    d0 = done_pulses; mr0 = mr_cycles; mw0 = mw_cycles;
    issue(1'b0, 32'h500, 10'd0);
    wait_done("t4_done", e);
    checks++; if (e != 0) begin errors++; $display("FAIL t4_latency: got %0d, required 0", e); end
    tick();
    checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL t4_done_pulses: got %0d, required 1", done_pulses - d0); end
    checks++; if (mr_cycles != mr0 || mw_cycles != mw0) begin errors++; $display("FAIL t4_no_access: got %0d accesses, required 0", (mr_cycles - mr0) + (mw_cycles - mw0)); end
    issue(1'b1, 32'h200, 10'd1);
    issue(1'b0, 32'h300, 10'd5);
    checks++; if (Address !== 32'h200) begin errors++; $display("FAIL t4_ignored_addr: got %h, required 200", Address); end
    checks++; if (wr_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL t4_ignored_state: wr_ready=%b busy=%b, required 1 1", wr_ready, busy); end
    exp_wa_q.push_back(32'h200); exp_wd_q.push_back(32'hCAFEF00D);
    push_word("t4_hs", 32'hCAFEF00D);
    wait_done("t4_done2", e);
    tick();
    checks++; if (mem[128] !== 32'hCAFEF00D) begin errors++; $display("FAIL t4_mem128: got %h, required cafef00d", mem[128]); end
  endtask

  task automatic test_abort_wrap();
    int n, dl0, mr0;
    mem[1023] = 32'hAAAA0001; mem[0] = 32'hBBBB0002; mem[1] = 32'hCCCC0003;
    exp_addr_q.push_back(32'hFFFFFFFC); exp_addr_q.push_back(32'h0);
    exp_rd_q.push_back(32'hAAAA0001); exp_rd_q.push_back(32'hBBBB0002);
    dl0 = delivered; mr0 = mr_cycles;
    rd_ready = 1'b1;
    issue(1'b0, 32'hFFFFFFFC, 10'd4);
    n = 0;
    while (!(rd_valid === 1'b1 && Address === 32'h4) && n < 20) begin tick(); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL t5_reach: second RD_HOLD not seen, required Address 4"); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL t5_valid: got %b, required 0", rd_valid); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t5_done: got %b, required 1", done); end
    tick(); tick();
    checks++; if (delivered - dl0 != 2) begin errors++; $display("FAIL t5_words: got %0d, required 2", delivered - dl0); end
    checks++; if (mr_cycles - mr0 != 2) begin errors++; $display("FAIL t5_reads: got %0d, required 2", mr_cycles - mr0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b, required 0", busy); end
  endtask

  task automatic test_reset_mid_write();
    mem[256] = 32'h0; mem[257] = 32'h0;
    issue(1'b1, 32'h403, 10'd2);
    wr_data = 32'h00000055; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL t6_in_issue: MemWrite=%b, required 1", MemWrite); end
    #2 reset = 1'b0;
    #1;
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL t6_memwrite: got %b, required 0", MemWrite); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy: got %b, required 0", busy); end
    @(negedge clk) reset = 1'b1;
    tick();
    checks++; if (mem[256] !== 32'h0) begin errors++; $display("FAIL t6_no_commit: got %h, required 0", mem[256]); end
    test_write();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_read();
    test_backpressure();
    test_write();
    test_zero_and_busy_start();
    test_abort_wrap();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
